// File: rtl/keypad_pkg.sv
// Shared definitions for the 4x4 active-low keypad emulator and its scanner:
// matrix size, key-code field layout, FSM state encoding and strobe helper.
package keypad_pkg;

  localparam int KEY_ROWS = 4;
  localparam int KEY_COLS = 4;

  // Key code layout: [3:2] row index, [1:0] column index.
  localparam int KEY_ROW_MSB = 3;
  localparam int KEY_ROW_LSB = 2;
  localparam int KEY_COL_MSB = 1;
  localparam int KEY_COL_LSB = 0;

  localparam logic [3:0] ALL_RELEASED = 4'b1111;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_BOUNCE = 2'd1,
    ST_HOLD   = 2'd2,
    ST_GAP    = 2'd3
  } state_e;

  // Active-low one-hot code selecting line idx.
  function automatic logic [3:0] strobe_low(input logic [1:0] idx);
    return ~(4'b0001 << idx);
  endfunction

endpackage

// File: rtl/keypad_row_drive.sv
// Combinational row response: pulls the latched key's row low only while the
// contact is closed and the scanner strobes exactly that key's column.
module keypad_row_drive
  import keypad_pkg::*;
(
  input  logic [3:0]          key_i,
  input  logic                pressed_i,
  input  logic [KEY_COLS-1:0] col_i,
  output logic [KEY_ROWS-1:0] row_o
);

  // NOTE: every output of an always_comb gets a default first so no latch is inferred.
  always_comb begin
    row_o = ALL_RELEASED;
    // Exact compare means several low columns never match: no ghosting.
    if (pressed_i && (col_i == strobe_low(key_i[KEY_COL_MSB:KEY_COL_LSB]))) begin
      row_o = strobe_low(key_i[KEY_ROW_MSB:KEY_ROW_LSB]);
    end
  end

endmodule

// File: rtl/keypad_emulator.sv
// Scripted 4x4 keypad: accepts one key press request at a time and plays it
// back as optional bounce, a stable hold and a forced release gap.
module keypad_emulator
  import keypad_pkg::*;
#(
  parameter int HOLD_W        = 24,
  parameter int GAP_CYCLES    = 16,
  parameter int BOUNCE_PULSES = 0,
  parameter int BOUNCE_LEN    = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [3:0]        col,
  output logic [3:0]        row,
  input  logic              req_valid,
  input  logic [3:0]        req_key,
  input  logic [HOLD_W-1:0] req_hold,
  output logic              req_ready,
  output logic              pressed,
  output logic              done
);

  localparam int GAP_N  = (GAP_CYCLES < 1) ? 1 : GAP_CYCLES;
  localparam int BLEN_N = (BOUNCE_LEN < 1) ? 1 : BOUNCE_LEN;

  localparam logic [HOLD_W-1:0] GAP_LOAD   = HOLD_W'(GAP_N);
  localparam logic [HOLD_W-1:0] BLEN_LOAD  = HOLD_W'(BLEN_N);
  localparam logic [15:0]       PULSE_LOAD = 16'(BOUNCE_PULSES);

  state_e            state_q, state_d;
  logic [HOLD_W-1:0] cnt_q, cnt_d;
  logic [HOLD_W-1:0] hold_q, hold_d;
  logic [15:0]       pulse_q, pulse_d;
  logic              closed_q, closed_d;
  logic [3:0]        key_q, key_d;
  logic              done_q, done_d;

  // NOTE: sequential state uses non-blocking assignments only, so every register
  // samples the values from before the edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      hold_q   <= '0;
      pulse_q  <= '0;
      closed_q <= 1'b0;
      key_q    <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      hold_q   <= hold_d;
      pulse_q  <= pulse_d;
      closed_q <= closed_d;
      key_q    <= key_d;
      done_q   <= done_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    hold_d   = hold_q;
    pulse_d  = pulse_q;
    closed_d = closed_q;
    key_d    = key_q;
    done_d   = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          key_d  = req_key;
          hold_d = (req_hold == '0) ? HOLD_W'(1) : req_hold;
          if (BOUNCE_PULSES > 0) begin
            state_d  = ST_BOUNCE;
            cnt_d    = BLEN_LOAD;
            pulse_d  = PULSE_LOAD;
            closed_d = 1'b1;
          end else begin
            state_d = ST_HOLD;
            cnt_d   = hold_d;
          end
        end
      end
      ST_BOUNCE: begin
        if (cnt_q != HOLD_W'(1)) begin
          cnt_d = cnt_q - 1'b1;
        end else if (closed_q) begin
          closed_d = 1'b0;
          cnt_d    = BLEN_LOAD;
        end else if (pulse_q == 16'd1) begin
          state_d = ST_HOLD;
          cnt_d   = hold_q;
        end else begin
          pulse_d  = pulse_q - 1'b1;
          closed_d = 1'b1;
          cnt_d    = BLEN_LOAD;
        end
      end
      ST_HOLD: begin
        if (cnt_q == HOLD_W'(1)) begin
          state_d = ST_GAP;
          cnt_d   = GAP_LOAD;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      ST_GAP: begin
        if (cnt_q == HOLD_W'(1)) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
          done_d  = 1'b1;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign req_ready = (state_q == ST_IDLE);
  assign pressed   = (state_q == ST_HOLD) || ((state_q == ST_BOUNCE) && closed_q);
  assign done      = done_q;

  keypad_row_drive u_row_drive (
    .key_i     (key_q),
    .pressed_i (pressed),
    .col_i     (col),
    .row_o     (row)
  );

endmodule
